// File: rtl/decode_ctrl_stage.sv
// Registered RV32I(+M) control decoder between fetch and execute.
// A 2-entry skid buffer decouples in_ready from out_ready.
module decode_ctrl_stage #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [5:0]       out_branch,
    output logic             out_jump,
    output logic             out_regWrite,
    output logic             out_memWrite,
    output logic             out_memRead,
    output logic             out_ASrc,
    output logic             out_BSrc,
    output logic             out_PCTargetSrc,
    output logic [2:0]       out_immSrc,
    output logic [1:0]       out_resultSrc,
    output logic [1:0]       out_ALUOp,
    output logic [1:0]       out_DQM,
    output logic             out_loadUnsigned,
    output logic             out_mulDiv,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [5:0] branch;
        logic       jump;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       a_src;
        logic       b_src;
        logic       pc_target_src;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic [1:0] dqm;
        logic       load_unsigned;
        logic       mul_div;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        ctrl_t           ctrl;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t      c;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ld, opi, aui, st, rr, lui, br, jalr, jal;
        logic       mext, legal;
        op   = instr[6:0];
        f3   = instr[14:12];
        f7   = instr[31:25];
        ld   = (op == 7'b0000011);
        opi  = (op == 7'b0010011);
        aui  = (op == 7'b0010111);
        st   = (op == 7'b0100011);
        rr   = (op == 7'b0110011);
        lui  = (op == 7'b0110111);
        br   = (op == 7'b1100011);
        jalr = (op == 7'b1100111);
        jal  = (op == 7'b1101111);
        mext = (ENABLE_M != 0) && rr && (f7 == 7'b0000001);

        legal = 1'b0;
        unique case (1'b1)
            ld:   legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            opi: begin
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal = 1'b1;
            end
            aui, lui, jal: legal = 1'b1;
            st:   legal = (f3 < 3'b011);
            rr:   legal = (f7 == 7'b0000000) || (f7 == 7'b0100000) || mext;
            br:   legal = (f3[2:1] != 2'b01);
            jalr: legal = (f3 == 3'b000);
            default: legal = 1'b0;
        endcase

        c               = '0;
        c.rd            = instr[11:7];
        c.rs1           = instr[19:15];
        c.rs2           = instr[24:20];
        c.funct3        = f3;
        c.jump          = jal | jalr;
        c.pc_target_src = br | jal;
        c.mem_write     = st;
        c.mem_read      = ld;
        c.reg_write     = !(st | br);
        c.a_src         = !aui;
        c.b_src         = !(rr | br);
        c.mul_div       = mext;
        c.load_unsigned = ld & f3[2];
        c.dqm           = (ld | st) ? f3[1:0] : 2'b00;

        if (ld)
            c.result_src = 2'b01;
        else if (lui)
            c.result_src = 2'b10;
        else if (jal | jalr)
            c.result_src = 2'b11;

        if (st)
            c.imm_src = 3'b001;
        else if (br)
            c.imm_src = 3'b010;
        else if (jal)
            c.imm_src = 3'b011;
        else if (aui | lui)
            c.imm_src = 3'b100;

        if (mext)
            c.alu_op = 2'b11;
        else if (rr | opi)
            c.alu_op = 2'b10;
        else if (br)
            c.alu_op = 2'b01;

        if (br) begin
            case (f3)
                3'b000:  c.branch = 6'b100000;
                3'b001:  c.branch = 6'b010000;
                3'b100:  c.branch = 6'b001000;
                3'b101:  c.branch = 6'b000100;
                3'b110:  c.branch = 6'b000010;
                3'b111:  c.branch = 6'b000001;
                default: c.branch = 6'b000000;
            endcase
        end

        // Illegal words carry only the flag so nothing downstream acts on them.
        if (!legal) begin
            c         = '0;
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    entry_t           in_entry;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           out_e;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic [CNT_W-1:0] cnt_q;

    assign in_entry.pc   = in_pc;
    assign in_entry.ctrl = decode(in_instr);

    assign in_ready = !rst && !skid_valid;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_valid && !out_ready) begin
            if (accept) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end else if (skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= accept;
            if (accept)
                main_q <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            cnt_q <= '0;
        else if (accept && in_entry.ctrl.illegal && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

    assign out_valid   = main_valid && !rst;
    assign out_e       = out_valid ? main_q : '0;
    assign illegal_cnt = rst ? '0 : cnt_q;

    assign out_pc           = out_e.pc;
    assign out_rd           = out_e.ctrl.rd;
    assign out_rs1          = out_e.ctrl.rs1;
    assign out_rs2          = out_e.ctrl.rs2;
    assign out_funct3       = out_e.ctrl.funct3;
    assign out_branch       = out_e.ctrl.branch;
    assign out_jump         = out_e.ctrl.jump;
    assign out_regWrite     = out_e.ctrl.reg_write;
    assign out_memWrite     = out_e.ctrl.mem_write;
    assign out_memRead      = out_e.ctrl.mem_read;
    assign out_ASrc         = out_e.ctrl.a_src;
    assign out_BSrc         = out_e.ctrl.b_src;
    assign out_PCTargetSrc  = out_e.ctrl.pc_target_src;
    assign out_immSrc       = out_e.ctrl.imm_src;
    assign out_resultSrc    = out_e.ctrl.result_src;
    assign out_ALUOp        = out_e.ctrl.alu_op;
    assign out_DQM          = out_e.ctrl.dqm;
    assign out_loadUnsigned = out_e.ctrl.load_unsigned;
    assign out_mulDiv       = out_e.ctrl.mul_div;
    assign out_illegal      = out_e.ctrl.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: queue-based reference model plus
// directed literal checks, two DUTs (ENABLE_M=0/CNT_W=16, ENABLE_M=1/CNT_W=3).
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst, flush, cnt_clr, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_pc;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3, a_imm;
    logic [5:0]  a_br;
    logic        a_jump, a_rw, a_mw, a_mr, a_as, a_bs, a_pt, a_lu, a_md, a_il;
    logic [1:0]  a_res, a_alu, a_dqm;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_pc;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_f3, b_imm;
    logic [5:0]  b_br;
    logic        b_jump, b_rw, b_mw, b_mr, b_as, b_bs, b_pt, b_lu, b_md, b_il;
    logic [1:0]  b_res, b_alu, b_dqm;
    logic [2:0]  b_cnt;

    decode_ctrl_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_funct3(a_f3), .out_branch(a_br), .out_jump(a_jump),
        .out_regWrite(a_rw), .out_memWrite(a_mw), .out_memRead(a_mr),
        .out_ASrc(a_as), .out_BSrc(a_bs), .out_PCTargetSrc(a_pt),
        .out_immSrc(a_imm), .out_resultSrc(a_res), .out_ALUOp(a_alu),
        .out_DQM(a_dqm), .out_loadUnsigned(a_lu), .out_mulDiv(a_md),
        .out_illegal(a_il), .illegal_cnt(a_cnt)
    );

    decode_ctrl_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_funct3(b_f3), .out_branch(b_br), .out_jump(b_jump),
        .out_regWrite(b_rw), .out_memWrite(b_mw), .out_memRead(b_mr),
        .out_ASrc(b_as), .out_BSrc(b_bs), .out_PCTargetSrc(b_pt),
        .out_immSrc(b_imm), .out_resultSrc(b_res), .out_ALUOp(b_alu),
        .out_DQM(b_dqm), .out_loadUnsigned(b_lu), .out_mulDiv(b_md),
        .out_illegal(b_il), .illegal_cnt(b_cnt)
    );

    logic [74:0] a_vec, b_vec;
    assign a_vec = {a_pc, a_rd, a_rs1, a_rs2, a_f3, a_br, a_jump, a_rw,
                    a_mw, a_mr, a_as, a_bs, a_pt, a_imm, a_res, a_alu,
                    a_dqm, a_lu, a_md, a_il};
    assign b_vec = {b_pc, b_rd, b_rs1, b_rs2, b_f3, b_br, b_jump, b_rw,
                    b_mw, b_mr, b_as, b_bs, b_pt, b_imm, b_res, b_alu,
                    b_dqm, b_lu, b_md, b_il};

    // Fields that stay meaningful on an illegal entry.
    localparam logic [74:0] ILL_MASK =
        {32'hFFFF_FFFF, 18'd0, 6'h3F, 4'hF, 3'd0, 9'd0, 1'b0, 2'b11};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [74:0] mdl(input logic [31:0] w,
                                        input logic [31:0] pc,
                                        input bit m);
        logic [6:0] op, f7;
        logic [2:0] f3, imm;
        logic [5:0] brv;
        logic [1:0] rs, alu, dqm;
        bit ok, j, rw, mw, mr, as, bs, pt, lu, md;
        int pos;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        ok = 0; j = 0; rw = 0; mw = 0; mr = 0; pt = 0; lu = 0; md = 0;
        as = 1; bs = 1; imm = 3'd0; rs = 2'd0; alu = 2'd0; dqm = 2'd0;
        brv = 6'd0;
        case (op)
            7'h03: begin
                ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
                mr = 1; rw = 1; rs = 2'd1; dqm = f3[1:0]; lu = f3[2];
            end
            7'h13: begin
                if (f3 == 3'd1)      ok = (f7 == 7'd0);
                else if (f3 == 3'd5) ok = (f7 == 7'd0 || f7 == 7'd32);
                else                 ok = 1;
                rw = 1; alu = 2'd2;
            end
            7'h17: begin ok = 1; rw = 1; as = 0; imm = 3'd4; end
            7'h23: begin ok = (f3 < 3'd3); mw = 1; imm = 3'd1; dqm = f3[1:0]; end
            7'h33: begin
                md = m && (f7 == 7'd1);
                ok = (f7 == 7'd0 || f7 == 7'd32 || md);
                rw = 1; bs = 0; alu = md ? 2'd3 : 2'd2;
            end
            7'h37: begin ok = 1; rw = 1; rs = 2'd2; imm = 3'd4; end
            7'h63: begin
                ok = (f3 != 3'd2 && f3 != 3'd3);
                pt = 1; bs = 0; alu = 2'd1; imm = 3'd2;
                // BEQ,BNE,BLT,BGE,BLTU,BGEU sit at positions 0..5 from bit5.
                pos = (f3 < 3'd2) ? int'(f3) : int'(f3) - 2;
                brv = 6'b100000 >> pos;
            end
            7'h67: begin ok = (f3 == 3'd0); j = 1; rw = 1; rs = 2'd3; end
            7'h6F: begin ok = 1; j = 1; pt = 1; rw = 1; rs = 2'd3; imm = 3'd3; end
            default: ok = 0;
        endcase
        if (!ok) return {pc, 42'd0, 1'b1};
        return {pc, w[11:7], w[19:15], w[24:20], f3, brv, j, rw, mw, mr,
                as, bs, pt, imm, rs, alu, dqm, lu, md, 1'b0};
    endfunction

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   rst_d = 1;
    bit   last_acc = 0;

    always @(posedge clk) begin
        bit          acc;
        logic [74:0] va, vb;
        acc = !rst && !flush && in_valid && (q.size() < 2);
        va  = mdl(in_instr, in_pc, 0);
        vb  = mdl(in_instr, in_pc, 1);
        if (rst || cnt_clr) cnt_a = 0;
        else if (acc && va[0] && cnt_a < 65535) cnt_a++;
        if (rst || cnt_clr) cnt_b = 0;
        else if (acc && vb[0] && cnt_b < 7) cnt_b++;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back('{w: in_instr, pc: in_pc});
        end
        last_acc = acc;
        rst_d    = rst;
    end

    always @(negedge clk) begin
        bit          ev;
        logic [74:0] va, vb;
        ev = !rst && (q.size() > 0);
        chk("a_in_ready", a_in_ready, !rst && q.size() < 2);
        chk("b_in_ready", b_in_ready, !rst && q.size() < 2);
        chk("a_out_valid", a_out_valid, ev);
        chk("b_out_valid", b_out_valid, ev);
        chk("a_cnt", a_cnt, rst ? 0 : cnt_a);
        chk("b_cnt", b_cnt, rst ? 0 : cnt_b);
        if (rst || rst_d) begin
            chk("a_reset_payload", a_vec, 0);
            chk("b_reset_payload", b_vec, 0);
        end else if (ev) begin
            va = mdl(q[0].w, q[0].pc, 0);
            vb = mdl(q[0].w, q[0].pc, 1);
            if (va[0]) chk("a_payload_ill", a_vec & ILL_MASK, va & ILL_MASK);
            else       chk("a_payload", a_vec, va);
            if (vb[0]) chk("b_payload_ill", b_vec & ILL_MASK, vb & ILL_MASK);
            else       chk("b_payload", b_vec, vb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        step();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        if ($urandom_range(0, 19) == 0) return w;
        case ($urandom_range(0, 10))
            0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h17;
            3: op = 7'h23;  4: op = 7'h33;  5: op = 7'h37;
            6: op = 7'h63;  7: op = 7'h67;  8: op = 7'h6F;
            9: op = 7'h33;
            default: op = 7'h0B;
        endcase
        w[6:0] = op;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'd0;
            1: w[31:25] = 7'd32;
            2: w[31:25] = 7'd1;
            default: ;
        endcase
        return w;
    endfunction

    logic [15:0] saved_cnt;
    logic [31:0] pc_n;

    initial begin
        rst = 1; flush = 0; cnt_clr = 0; in_valid = 0; out_ready = 1;
        in_instr = 0; in_pc = 0;
        #1;
        chk("lit_reset_in_ready", a_in_ready, 0);
        repeat (3) step();
        chk("lit_reset_out_valid", a_out_valid, 0);
        chk("lit_reset_cnt", a_cnt, 0);
        rst = 0;
        step();

        send(32'h00500093, 32'h1000);
        chk("lit_addi_valid", a_out_valid, 1);
        chk("lit_addi_regs", {a_rd, a_rs1}, {5'd1, 5'd0});
        chk("lit_addi_ctrl", {a_rw, a_alu, a_bs, a_imm, a_il},
            {1'b1, 2'b10, 1'b1, 3'b000, 1'b0});

        send(32'h00208463, 32'h1004);
        chk("lit_beq", {a_br, a_rw, a_pt, a_imm, a_alu},
            {6'b100000, 1'b0, 1'b1, 3'b010, 2'b01});

        send(32'h0000C083, 32'h1008);
        chk("lit_lbu", {a_mr, a_res, a_dqm, a_lu},
            {1'b1, 2'b01, 2'b00, 1'b1});
        send(32'h00002083, 32'h100C);
        chk("lit_lw", {a_mr, a_res, a_dqm, a_lu},
            {1'b1, 2'b01, 2'b10, 1'b0});

        send(32'h0000B083, 32'h1010);
        chk("lit_ld011", {a_il, a_rw, a_mw}, 3'b100);
        send(32'hFFFFFFFF, 32'h1014);
        chk("lit_allones", {a_il, a_rw, a_mw}, 3'b100);
        chk("lit_cnt2", a_cnt, 2);

        send(32'h02208033, 32'h1018);
        chk("lit_mul_m1", {b_alu, b_md, b_il}, {2'b11, 1'b1, 1'b0});
        chk("lit_mul_m0", a_il, 1);
        chk("lit_cnt3", a_cnt, 3);
        in_valid = 0;
        step();

        out_ready = 0;
        send(32'h00100093, 32'h100);
        send(32'h00200113, 32'h104);
        send(32'h00300193, 32'h108);
        chk("lit_bp_hold_pc", a_pc, 32'h100);
        chk("lit_bp_in_ready", a_in_ready, 0);
        step();
        chk("lit_bp_hold_pc2", a_pc, 32'h100);
        out_ready = 1;
        #1;
        chk("lit_bp_emit_a", {a_out_valid, a_pc}, {1'b1, 32'h100});
        step();
        chk("lit_bp_emit_b", {a_out_valid, a_pc}, {1'b1, 32'h104});
        chk("lit_bp_ready_back", a_in_ready, 1);
        step();
        chk("lit_bp_emit_c", {a_out_valid, a_pc}, {1'b1, 32'h108});
        in_valid = 0;
        step();
        chk("lit_bp_empty", a_out_valid, 0);

        out_ready = 0;
        saved_cnt = a_cnt;
        send(32'h00400213, 32'h200);
        send(32'h00500293, 32'h204);
        chk("lit_fl_full", a_in_ready, 0);
        flush = 1;
        in_instr = 32'hFFFFFFFF;
        in_pc = 32'h208;
        step();
        flush = 0;
        in_valid = 0;
        chk("lit_fl_valid", a_out_valid, 0);
        out_ready = 1;
        step();
        chk("lit_fl_nothing", a_out_valid, 0);
        chk("lit_fl_cnt", a_cnt, saved_cnt);

        pc_n = 32'h4000;
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            cnt_clr   = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_instr = rnd_instr();
                pc_n     = pc_n + 32'd4;
                in_pc    = pc_n;
            end
            step();
        end

        rst = 0; flush = 0; cnt_clr = 0; in_valid = 0; out_ready = 1;
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered, flow-controlled successor to the combinational main decoder.
- Takes a fetched instruction and PC on a valid/ready interface and decodes the full control bundle, register indices and illegal-instruction flag.
- Presents the result one cycle later through a 2-entry skid buffer, so fetch and execute can stall independently.
- Sits between the fetch stage and the register-read/execute stage.

Parameters:
XLEN, 32, width of PC passthrough
ENABLE_M, 0, 1 = decode RV32M (R-type funct7=0000001) as legal
CNT_W, 16, width of saturating illegal-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered entries (branch redirect)
cnt_clr  in  1  clear illegal counter
in_valid  in  1  instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded entry valid
out_ready  in  1  consumer accepts
out_pc  out  XLEN  PC of entry
out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
out_funct3  out  3  instr[14:12]
out_branch  out  6  one-hot BEQ,BNE,BLT,BGE,BLTU,BGEU (bit5..bit0)
out_jump, out_regWrite, out_memWrite, out_memRead, out_ASrc, out_BSrc, out_PCTargetSrc  out  1 each
out_immSrc  out  3;  out_resultSrc  out  2;  out_ALUOp  out  2;  out_DQM  out  2
out_loadUnsigned, out_mulDiv, out_illegal  out  1 each
illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset: both buffer entries invalid.
  - All out_* and illegal_cnt are 0 while rst is high and the cycle after.
  - in_ready is 0 while rst is high.
- Decode (combinational on in_instr, registered on accept). Fields:
  - jump: JAL or JALR.
  - PCTargetSrc: BRANCH or JAL.
  - memWrite: STORE.
  - memRead: LOAD.
  - regWrite: 1 except STORE/BRANCH.
  - ASrc: 0 for AUIPC only.
  - BSrc: 0 for R-type and BRANCH.
  - resultSrc: LOAD=01, LUI=10, JAL/JALR=11, else 00.
  - immSrc: I-type (LOAD, OP-IMM, JALR)=000, S=001, B=010, J=011, U=100.
  - ALUOp: R/OP-IMM=10, BRANCH=01, else 00. With ENABLE_M=1 and R-type funct7=0000001: ALUOp=11 and mulDiv=1.
  - DQM: funct3[1:0] for LOAD/STORE, else 00.
  - loadUnsigned: funct3[2] for LOAD, else 0.
- Illegal when any of the following holds:
  - instr[1:0]≠11.
  - Opcode outside {LOAD, OP-IMM, AUIPC, STORE, R, LUI, BRANCH, JALR, JAL}.
  - BRANCH funct3 ∈{010,011}.
  - LOAD funct3 ∈{011,110,111}.
  - STORE funct3 ≥011.
  - JALR funct3≠000.
  - R funct7 ∉{0000000,0100000} (plus 0000001 when ENABLE_M=1).
  - OP-IMM shift (funct3 001/101) with funct7 ∉{0000000, 0100000 only for 101}.
- Illegal entry outputs: illegal=1; regWrite, memWrite, memRead, jump, branch, mulDiv forced 0. Other fields are don't-care and driven 0.
- Handshake:
  - Accept when in_valid && in_ready. Entry is visible on out_* the next cycle (latency 1).
  - Output is held stable while out_valid && !out_ready.
  - in_ready = !rst && !skid_valid, i.e. registered with no combinational path from out_ready.
  - Accept while the main entry is stalled: the word goes to the skid entry.
  - When main drains, skid moves to main in the same edge.
  - Simultaneous drain and accept with skid empty: the new entry goes directly to main.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- flush (priority over accept):
  - Both entries invalid next cycle.
  - An in_valid word presented in the same cycle is discarded and not counted.
  - out_valid=0 the next cycle.
- illegal_cnt:
  - +1 per accepted illegal word (not flushed).
  - Saturates at 2^CNT_W−1.
  - cnt_clr has priority: clears to 0, and a same-cycle illegal accept is not counted.

Test Plan:
- Reset then in_instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle:
  - out_valid=1, rd=1, rs1=0, regWrite=1, ALUOp=10, BSrc=1, immSrc=000, illegal=0.
- in_instr=0x00208463 (beq) -> out_branch=100000, regWrite=0, PCTargetSrc=1, immSrc=010, ALUOp=01.
- Loads 0x0000C083 (lbu) and 0x00002083 (lw) -> memRead=1 and resultSrc=01 for both:
  - lbu: DQM=00, loadUnsigned=1.
  - lw: DQM=10, loadUnsigned=0.
- 0x0000B083 (load funct3=011) and 0xFFFFFFFF -> illegal=1, regWrite=0, memWrite=0; illegal_cnt=2.
- Backpressure stream:
  - Stream A,B,C with out_ready=0 for 3 cycles -> A held on out, B in skid, in_ready=0, C held by source.
  - Then out_ready=1 -> A,B,C emitted in order on consecutive cycles.
- flush and M-extension:
  - flush with both entries full and in_valid=1 -> out_valid=0 next cycle; nothing emitted; illegal_cnt unchanged.
  - ENABLE_M=1 with 0x02208033 (mul) -> ALUOp=11, mulDiv=1.
  - ENABLE_M=0 with the same word -> illegal=1.
